// File: rtl/rr_arbiter10_if.sv
// rr_arbiter10_if: request/grant bundle between requesters and the round-robin arbiter.
interface rr_arbiter10_if #(parameter int NREQ = 10, parameter int IDXW = 4);
  logic            en;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            timeout;
  modport master (output en, req, done, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input en, req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_arbiter10.sv
// rr_arbiter10: round-robin arbiter, registered one-hot grant held until done.
// Optional grant timeout enabled by RR_ARBITER10_TIMEOUT_EN.
module rr_arbiter10 #(
    parameter int NREQ     = 10,
    parameter int IDXW     = 4,
    parameter int HOLD_MAX = 15
) (
    input logic           clk,
    input logic           rst,
    rr_arbiter10_if.slave bus
);
`ifdef RR_ARBITER10_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [IDXW:0] NR = (IDXW + 1)'(NREQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d, idx_q, idx_d, off, win;
    logic [NREQ-1:0] gnt_q, gnt_d, rot;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d, tmo, rel;
    logic [IDXW:0]   sum, sum_w;
    // Rotate requests so offset 0 is the pointer; lowest set offset wins.
    always_comb begin
      rot = NREQ'({bus.req, bus.req} >> ptr_q);
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--)
        if (rot[k]) off = IDXW'(k);
      sum   = {1'b0, ptr_q} + {1'b0, off};
      sum_w = sum - NR;
      win   = (sum >= NR) ? sum_w[IDXW-1:0] : sum[IDXW-1:0];
    end
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = '0;
      to_d    = 1'b0;
      tmo     = TO_EN && (cnt_q == CW'(HOLD_MAX - 1));
      rel     = bus.done || tmo;
      if (state_q == IDLE) begin
        if (bus.en && |bus.req) begin
          state_d = GRANT;
          idx_d   = win;
        end
      end else if (rel) begin
        state_d = IDLE;
        ptr_d   = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        to_d    = !bus.done;
      end else begin
        cnt_d = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
      end
      gnt_d = (state_d == GRANT) ? NREQ'(1) << idx_d : '0;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        idx_q   <= '0;
        gnt_q   <= '0;
        cnt_q   <= '0;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        idx_q   <= idx_d;
        gnt_q   <= gnt_d;
        cnt_q   <= cnt_d;
        to_q    <= to_d;
      end
    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = (state_q == GRANT);
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_arbiter10.sv
// tb_rr_arbiter10: directed vector table plus hand sequences for rr_arbiter10.
module tb_rr_arbiter10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    rr_arbiter10_if #(.NREQ(10), .IDXW(4)) bus ();
    rr_arbiter10 #(.NREQ(10), .IDXW(4), .HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
      logic       en;
      logic [9:0] req;
      logic       done;
      logic       vld;
      logic [3:0] idx;
      logic [9:0] gnt;
    } vec_t;
    vec_t tv[13];
    task automatic check(input string nm, input logic ev, input logic [3:0] ei,
                         input logic [9:0] eg, input logic et);
      checks++;
      if (bus.gnt_vld !== ev || bus.gnt_idx !== ei || bus.gnt !== eg || bus.timeout !== et) begin
        failures++;
        $display("FAIL %s: got vld=%b idx=%0d gnt=%h to=%b, want vld=%b idx=%0d gnt=%h to=%b",
                 nm, bus.gnt_vld, bus.gnt_idx, bus.gnt, bus.timeout, ev, ei, eg, et);
      end
    endtask
    task automatic step();
      @(posedge clk);
      #1;
    endtask
    task automatic drive(input logic e, input logic [9:0] r, input logic d);
      bus.en   = e;
      bus.req  = r;
      bus.done = d;
    endtask
    task automatic do_reset();
      drive(1'b0, '0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
    endtask
    initial begin
      tv[0]  = '{1'b1, 10'h020, 1'b0, 1'b1, 4'd5, 10'h020};
      tv[1]  = '{1'b1, 10'h020, 1'b0, 1'b1, 4'd5, 10'h020};
      tv[2]  = '{1'b0, 10'h000, 1'b0, 1'b1, 4'd5, 10'h020};
      tv[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd5, 10'h000};
      tv[4]  = '{1'b0, 10'h000, 1'b0, 1'b0, 4'd5, 10'h000};
      tv[5]  = '{1'b1, 10'h3FF, 1'b1, 1'b1, 4'd6, 10'h040};
      tv[6]  = '{1'b1, 10'h3FF, 1'b1, 1'b0, 4'd6, 10'h000};
      tv[7]  = '{1'b1, 10'h3FF, 1'b0, 1'b1, 4'd7, 10'h080};
      tv[8]  = '{1'b0, 10'h204, 1'b1, 1'b0, 4'd7, 10'h000};
      tv[9]  = '{1'b1, 10'h204, 1'b0, 1'b1, 4'd9, 10'h200};
      tv[10] = '{1'b0, 10'h204, 1'b1, 1'b0, 4'd9, 10'h000};
      tv[11] = '{1'b1, 10'h204, 1'b0, 1'b1, 4'd2, 10'h004};
      tv[12] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd2, 10'h000};
      do_reset();
      check("reset", 1'b0, 4'd0, 10'h000, 1'b0);
      for (int i = 0; i < 13; i++) begin
        drive(tv[i].en, tv[i].req, tv[i].done);
        step();
        check($sformatf("vec%0d", i), tv[i].vld, tv[i].idx, tv[i].gnt, 1'b0);
      end
      do_reset();
      for (int k = 0; k < 11; k++) begin
        drive(1'b1, 10'h3FF, 1'b0);
        step();
        check($sformatf("rot_grant%0d", k), 1'b1, 4'(k % 10), 10'(1) << (k % 10), 1'b0);
        bus.done = 1'b1;
        step();
        check($sformatf("rot_gap%0d", k), 1'b0, 4'(k % 10), 10'h000, 1'b0);
      end
      do_reset();
      drive(1'b0, 10'h001, 1'b0);
      for (int k = 0; k < 10; k++) begin
        step();
        check($sformatf("en_gate%0d", k), 1'b0, 4'd0, 10'h000, 1'b0);
      end
      bus.en = 1'b1;
      step();
      check("en_grant", 1'b1, 4'd0, 10'h001, 1'b0);
      drive(1'b0, '0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        step();
        check($sformatf("en_hold%0d", k), 1'b1, 4'd0, 10'h001, 1'b0);
      end
      bus.done = 1'b1;
      step();
      check("en_release", 1'b0, 4'd0, 10'h000, 1'b0);
      do_reset();
      drive(1'b1, 10'h020, 1'b0);
      step();
      check("pre_rst_grant", 1'b1, 4'd5, 10'h020, 1'b0);
      #3 rst = 1'b1;
      #1 check("async_rst", 1'b0, 4'd0, 10'h000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 10'h3FF, 1'b0);
      step();
      check("post_rst_grant", 1'b1, 4'd0, 10'h001, 1'b0);
`ifdef RR_ARBITER10_TIMEOUT_EN
      do_reset();
      drive(1'b1, 10'h018, 1'b0);
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("to_hold%0d", k), 1'b1, 4'd3, 10'h008, 1'b0);
      end
      step();
      check("to_revoke", 1'b0, 4'd3, 10'h000, 1'b1);
      step();
      check("to_next", 1'b1, 4'd4, 10'h010, 1'b0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
endmodule

// File: doc/rr_arbiter10.md
Name: rr_arbiter10

Overview:
- Round-robin arbiter sharing one resource among 10 requesters.
- Selects a 4-bit winner index and drives a one-hot 10-bit grant: the same index-to-one-hot mapping as the team's 4:10 decoder, now registered and sequenced.
- Sits between requesting channels and the shared decoder-selected resource; each grant is held until the owner signals done.

Parameters:
- NREQ, 10, number of requesters; legal range 2..16.
- IDXW, 4, width of the grant index; must satisfy 2^IDXW >= NREQ.
- HOLD_MAX, 15, maximum cycles a grant may be held; used only when TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enables new grants; does not affect a grant already issued.
- req  input  NREQ  request vector; bit i = requester i.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  NREQ  registered one-hot grant; all zeros when no grant.
- gnt_idx  output  IDXW  registered index of the current or most recent winner.
- gnt_vld  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, at any time, including mid-grant):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, rotation pointer ptr=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE -> GRANT:
  - Taken at a rising edge where en=1 and req!=0.
  - Winner = first set req bit scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - Winner is registered into gnt_idx; gnt = one-hot(winner); gnt_vld=1.
  - Latency: outputs are valid in the cycle after the sampling edge.
- IDLE hold: with en=0 or req=0, remain in IDLE; gnt=0, gnt_vld=0, gnt_idx keeps its last value.
- GRANT hold:
  - Grant is held while done=0, regardless of en or req changes (the owner dropping req does not release).
  - Hold counter increments each GRANT cycle.
- GRANT -> IDLE:
  - Taken at the edge where done=1: gnt=0, gnt_vld=0.
  - ptr = gnt_idx+1, wrapping NREQ-1 -> 0. Counter cleared.
- Back-to-back grants: a mandatory one-cycle IDLE gap follows every release (gnt_vld low for at least one cycle).
- done while in IDLE is ignored.
- req bits at index >= NREQ do not exist; gnt_idx never exceeds NREQ-1.
- Fairness: a requester that holds req high is granted within NREQ-1 other grants.
- gnt is always exactly one-hot or all zeros; gnt_vld == |gnt at all times.

Optional Feature:
- Macro: RR_ARBITER10_TIMEOUT_EN.
- Defined:
  - At the edge where the hold counter reaches HOLD_MAX with done still 0, the grant is revoked exactly as for done.
  - ptr advances past the revoked owner.
  - timeout pulses high for one cycle, aligned with gnt_vld falling.
  - done and timeout on the same edge count as a normal release: timeout=0.
- Not defined: grants are held indefinitely; timeout is tied to 0; the counter may be omitted.

Test Plan:
- Reset: assert rst mid-grant (gnt_idx=5) -> immediately gnt=0, gnt_vld=0, gnt_idx=0; first post-reset grant for req=all ones is index 0.
- Single request: en=1, req=10'h020 -> next cycle gnt_idx=5, gnt=10'h020, gnt_vld=1; held until done=1, then gnt=0 for at least one cycle.
- Rotation and wrap: req=10'h3FF held, done pulsed one cycle after each grant -> grant order 0,1,2,...,9,0 with one idle cycle between grants.
- Pointer skip: after a grant to 7, req=10'h204 -> grant 9, then after release grant 2.
- Enable gating: en=0, req=10'h001 -> no grant for 10 cycles; en=1 -> grant 0; drop en and req during the grant -> grant held until done.
- Timeout (RR_ARBITER10_TIMEOUT_EN, HOLD_MAX=4): req=10'h008 and 10'h010, done never -> grant 3 revoked after 4 cycles with a one-cycle timeout pulse, then grant 4.
